// File: rtl/write_ptr_ctrl_if.sv
// write_ptr_ctrl_if: producer request, synchronized read pointer and write-side status of the async FIFO
interface write_ptr_ctrl_if #(parameter int ADDR_W = 5);
  logic              write;
  logic [ADDR_W:0]   rptrs;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wptr;
  logic              fullflag;
  logic              almost_full;
  logic [ADDR_W:0]   wlevel;
  logic              overflow;
  modport master (output write, rptrs, input wen, waddr, wptr, fullflag, almost_full, wlevel, overflow);
  modport slave  (input write, rptrs, output wen, waddr, wptr, fullflag, almost_full, wlevel, overflow);
endinterface

// File: rtl/write_ptr_ctrl.sv
// write_ptr_ctrl: async FIFO write-domain pointer, full/level/overflow logic; WPTR_ALMOST_FULL_EN builds wlevel and almost_full
module write_ptr_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int AFULL_TH = 28
) (
  input logic             clkw,
  input logic             resetw,
  write_ptr_ctrl_if.slave bus
);
  logic [ADDR_W:0] wbin, wbin_next, wgray_next, wptr_q;
  logic            full_q, ovf_q, accept;
  assign accept     = bus.write & ~full_q;
  assign wbin_next  = wbin + {{ADDR_W{1'b0}}, accept};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign bus.wen      = accept & ~resetw;
  assign bus.waddr    = wbin[ADDR_W-1:0];
  assign bus.wptr     = wptr_q;
  assign bus.fullflag = full_q;
  assign bus.overflow = ovf_q;
  always_ff @(posedge clkw) begin
    if (resetw) begin
      wbin   <= '0;
      wptr_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      wptr_q <= wgray_next;
      full_q <= wgray_next == {~bus.rptrs[ADDR_W:ADDR_W-1], bus.rptrs[ADDR_W-2:0]};
      ovf_q  <= ovf_q | (bus.write & full_q);
    end
  end
`ifdef WPTR_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] TH = (ADDR_W+1)'(AFULL_TH);
  logic [ADDR_W:0] rbin, level_next, wlevel_q;
  logic            af_q;
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDR_W; i++) rbin[i] = ^(bus.rptrs >> i);
  end
  assign level_next      = wbin_next - rbin;
  assign bus.wlevel      = wlevel_q;
  assign bus.almost_full = af_q;
  always_ff @(posedge clkw) begin
    if (resetw) begin
      wlevel_q <= '0;
      af_q     <= 1'b0;
    end else begin
      wlevel_q <= level_next;
      af_q     <= level_next >= TH;
    end
  end
`else
  assign bus.wlevel      = '0;
  assign bus.almost_full = 1'b0;
`endif
endmodule

// File: tb/tb_write_ptr_ctrl.sv
// tb_write_ptr_ctrl: scoreboard bench for write_ptr_ctrl; expects wlevel/almost_full only when WPTR_ALMOST_FULL_EN is defined
module tb_write_ptr_ctrl;
  localparam int AW = 5;
  localparam int D  = 32;
  localparam int TH = 28;
`ifdef WPTR_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif
  typedef struct {
    logic [AW:0] wptr;
    logic        full;
    logic        af;
    logic [AW:0] lvl;
    logic        ovf;
  } exp_t;
  logic clkw = 1'b0;
  logic resetw;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];
  logic [AW:0] m_wbin = '0;
  logic        m_full = 1'b0;
  logic        m_ovf = 1'b0;
  logic [AW:0] prev_wptr;
  write_ptr_ctrl_if #(.ADDR_W(AW)) bus ();
  write_ptr_ctrl #(.ADDR_W(AW), .AFULL_TH(TH)) dut (.clkw(clkw), .resetw(resetw), .bus(bus));
  always #5 clkw = ~clkw;
  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  task automatic step(input logic w, input logic [AW:0] r, input logic rst);
    exp_t        e;
    logic        acc;
    logic [AW:0] lvl;
    bus.write = w;
    bus.rptrs = gray(r);
    resetw    = rst;
    #1;
    acc = w && !m_full && !rst;
    chk("wen", bus.wen, acc);
    if (!rst) chk("waddr", bus.waddr, m_wbin[AW-1:0]);
    if (rst) begin
      m_wbin = '0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
      lvl    = '0;
    end else begin
      m_ovf  = m_ovf | (w & m_full);
      m_wbin = m_wbin + acc;
      lvl    = m_wbin - r;
      m_full = lvl == (AW+1)'(D);
    end
    e.wptr = gray(m_wbin);
    e.full = m_full;
    e.af   = AF_EN && lvl >= (AW+1)'(TH);
    e.lvl  = AF_EN ? lvl : '0;
    e.ovf  = m_ovf;
    sb.push_back(e);
    @(posedge clkw);
    #1;
    e = sb.pop_front();
    chk("wptr", bus.wptr, e.wptr);
    chk("fullflag", bus.fullflag, e.full);
    chk("almost_full", bus.almost_full, e.af);
    chk("wlevel", bus.wlevel, e.lvl);
    chk("overflow", bus.overflow, e.ovf);
  endtask
  initial begin
    bus.write = 1'b0;
    bus.rptrs = '0;
    resetw    = 1'b1;
    @(posedge clkw);
    #1;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < D; i++) begin
      step(1'b1, '0, 1'b0);
      if (i == TH - 2) chk("af_before_th", bus.almost_full, 1'b0);
      if (i == TH - 1) chk("af_at_th", bus.almost_full, AF_EN);
    end
    chk("fill_wptr", bus.wptr, 6'b110000);
    chk("fill_full", bus.fullflag, 1'b1);
    chk("fill_level", bus.wlevel, AF_EN ? 6'd32 : 6'd0);
    step(1'b1, '0, 1'b0);
    chk("overfill_wptr", bus.wptr, 6'b110000);
    chk("overfill_ovf", bus.overflow, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("ovf_sticky", bus.overflow, 1'b1);
    step(1'b0, 6'd1, 1'b0);
    chk("release_full", bus.fullflag, 1'b0);
    chk("release_level", bus.wlevel, AF_EN ? 6'd31 : 6'd0);
    step(1'b1, 6'd1, 1'b0);
    chk("refull_full", bus.fullflag, 1'b1);
    chk("refull_wptr", bus.wptr, 6'b110001);
    for (int i = 0; i <= 80; i++) begin
      prev_wptr = bus.wptr;
      step(1'b1, m_wbin - 6'd3, 1'b0);
      if (i > 0) chk("gray_1bit", $countones(prev_wptr ^ bus.wptr), 1);
      if (i > 0) chk("wrap_notfull", bus.fullflag, 1'b0);
    end
    chk("wrap_level", bus.wlevel, AF_EN ? 6'd4 : 6'd0);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, '0, 1'b0);
    chk("mid_wptr_pre", bus.wptr, gray(6'd10));
    step(1'b1, '0, 1'b1);
    chk("mid_rst_wptr", bus.wptr, 6'd0);
    chk("mid_rst_level", bus.wlevel, 6'd0);
    chk("mid_rst_full", bus.fullflag, 1'b0);
    chk("mid_rst_ovf", bus.overflow, 1'b0);
    step(1'b1, '0, 1'b0);
    chk("post_rst_wptr", bus.wptr, 6'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
